// File: rtl/mask_prng_if.sv
// Seed/consume handshake bundle between a randomness consumer and mask_prng.
//   seed_valid, seed : seed offer from the consumer side
//   seed_ready       : seed acceptance (always 1 out of reset)
//   seed_err         : one-cycle pulse when an all-zero seed was rejected
//   en               : consumer takes the current z this cycle
//   z, z_valid       : current random word and its freshness flag
//   reseed_req       : generator needs a seed before producing more output
interface mask_prng_if #(
  parameter int unsigned OUT_W = 20
);
  logic              seed_valid;
  logic [63:0]       seed;
  logic              seed_ready;
  logic              seed_err;
  logic              en;
  logic [OUT_W-1:0]  z;
  logic              z_valid;
  logic              reseed_req;

  // Consumer side: offers seeds and consumes words.
  modport master (
    output seed_valid, seed, en,
    input  seed_ready, seed_err, z, z_valid, reseed_req
  );

  // Generator side.
  modport slave (
    input  seed_valid, seed, en,
    output seed_ready, seed_err, z, z_valid, reseed_req
  );
endinterface

// File: rtl/mask_prng.sv
// Fresh-randomness source for one masked S-box lane.
// A 64-bit Fibonacci LFSR advances OUT_W steps per consumed word, after a
// seed load and WARMUP discarded advances. After RESEED_LIMIT consumed words
// the block stops producing output until a new seed is supplied.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mask_prng_if slave modport (seed handshake, en, z, z_valid,
//          seed_err, reseed_req)
module mask_prng #(
  parameter int unsigned OUT_W        = 20,
  parameter int unsigned WARMUP       = 4,
  parameter int unsigned RESEED_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  mask_prng_if.slave   bus
);

  localparam int unsigned LFSR_W    = 64;
  localparam int unsigned USE_W     = $clog2(RESEED_LIMIT + 1);
  localparam int unsigned WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned WARM_LAST = (WARMUP == 0) ? 0 : WARMUP - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WARM      = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [USE_W-1:0]    use_q, use_d;
  logic                seed_err_q, seed_err_d;
  logic                z_valid_q, z_valid_d;
  logic                reseed_req_q, reseed_req_d;

  // One advance: OUT_W single LFSR steps unrolled into one cycle.
  function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    logic              fb;
    t = s;
    for (int i = 0; i < int'(OUT_W); i++) begin
      fb = t[63] ^ t[62] ^ t[60] ^ t[59];
      t  = {t[62:0], fb};
    end
    return t;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= '0;
      warm_q       <= '0;
      use_q        <= '0;
      seed_err_q   <= 1'b0;
      z_valid_q    <= 1'b0;
      reseed_req_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      warm_q       <= warm_d;
      use_q        <= use_d;
      seed_err_q   <= seed_err_d;
      z_valid_q    <= z_valid_d;
      reseed_req_q <= reseed_req_d;
    end
  end

  // Next-state logic. A seed offer outranks en in every state.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_d     = warm_q;
    use_d      = use_q;
    seed_err_d = 1'b0;

    if (bus.seed_valid) begin
      if (bus.seed == '0) begin
        // A zero seed would lock the LFSR; reject and leave everything as is.
        seed_err_d = 1'b1;
      end else begin
        lfsr_d  = bus.seed;
        warm_d  = '0;
        use_d   = '0;
        state_d = (WARMUP == 0) ? RUN : WARM;
      end
    end else begin
      case (state_q)
        WARM: begin
          lfsr_d = advance(lfsr_q);
          if (warm_q == WARM_W'(WARM_LAST)) begin
            state_d = RUN;
          end else begin
            warm_d = warm_q + WARM_W'(1);
          end
        end
        RUN: begin
          if (bus.en) begin
            lfsr_d = advance(lfsr_q);
            use_d  = use_q + USE_W'(1);
            // Counter saturates into EXHAUSTED, so it never wraps.
            if (use_d == USE_W'(RESEED_LIMIT)) begin
              state_d = EXHAUSTED;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Status flags are registered from the next state.
    z_valid_d    = (state_d == RUN);
    reseed_req_d = (state_d == IDLE) || (state_d == EXHAUSTED);
  end

  assign bus.seed_ready = 1'b1;
  assign bus.seed_err   = seed_err_q;
  assign bus.z          = lfsr_q[OUT_W-1:0];
  assign bus.z_valid    = z_valid_q;
  assign bus.reseed_req = reseed_req_q;

endmodule

// File: tb/tb_mask_prng.sv
// Directed bench for mask_prng: three instances cover WARMUP=0,
// WARMUP=4 and a short RESEED_LIMIT=3 configuration.
module tb_mask_prng;

  localparam int unsigned OUT_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mask_prng_if #(.OUT_W(OUT_W)) b0 ();
  mask_prng_if #(.OUT_W(OUT_W)) b4 ();
  mask_prng_if #(.OUT_W(OUT_W)) b3 ();

  mask_prng #(.OUT_W(OUT_W), .WARMUP(0), .RESEED_LIMIT(1024)) u_w0 (
    .clk(clk), .rst(rst), .bus(b0));
  mask_prng #(.OUT_W(OUT_W), .WARMUP(4), .RESEED_LIMIT(1024)) u_w4 (
    .clk(clk), .rst(rst), .bus(b4));
  mask_prng #(.OUT_W(OUT_W), .WARMUP(0), .RESEED_LIMIT(3)) u_l3 (
    .clk(clk), .rst(rst), .bus(b3));

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: n single LFSR steps from s.
  function automatic logic [63:0] ref_steps(input logic [63:0] s, input int n);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    return t;
  endfunction

  logic [63:0] exp_state;

  initial begin
    b0.seed_valid = 1'b0; b0.seed = '0; b0.en = 1'b0;
    b4.seed_valid = 1'b0; b4.seed = '0; b4.en = 1'b0;
    b3.seed_valid = 1'b0; b3.seed = '0; b3.en = 1'b0;

    tick(); tick();
    rst = 1'b0;

    // Reset values, then idle for 5 cycles.
    check("rst_seed_ready", 64'(b0.seed_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("idle_z",          64'(b0.z),          64'd0);
      check("idle_z_valid",    64'(b0.z_valid),    64'd0);
      check("idle_reseed_req", 64'(b0.reseed_req), 64'd1);
      check("idle_seed_err",   64'(b0.seed_err),   64'd0);
      tick();
    end

    // WARMUP=0, seed=1.
    b0.seed_valid = 1'b1; b0.seed = 64'h1;
    tick();
    b0.seed_valid = 1'b0;
    check("w0_load_valid",  64'(b0.z_valid),    64'd1);
    check("w0_load_z",      64'(b0.z),          64'h00001);
    check("w0_load_reseed", 64'(b0.reseed_req), 64'd0);
    b0.en = 1'b1; tick(); b0.en = 1'b0;
    check("w0_adv1_z", 64'(b0.z), 64'h00000);          // state = 1<<20
    b0.en = 1'b1; tick(); tick(); b0.en = 1'b0;
    check("w0_adv3_z", 64'(b0.z), 64'h00001);          // state = (1<<60)|1
    tick();
    check("w0_hold_z", 64'(b0.z), 64'h00001);

    // Zero seed in RUN: error pulse, nothing else changes.
    b0.seed_valid = 1'b1; b0.seed = 64'h0;
    tick();
    b0.seed_valid = 1'b0;
    check("zero_seed_err",   64'(b0.seed_err), 64'd1);
    check("zero_seed_z",     64'(b0.z),        64'h00001);
    check("zero_seed_valid", 64'(b0.z_valid),  64'd1);
    tick();
    check("zero_seed_err_clr", 64'(b0.seed_err), 64'd0);
    b0.en = 1'b1; tick(); b0.en = 1'b0;
    check("zero_seed_next_z", 64'(b0.z), 64'hB0000);   // bits {20,19,17,16}

    // Seed and en together in RUN: reload, no advance.
    b0.seed_valid = 1'b1; b0.seed = 64'h0000_1234_000A_BCDE; b0.en = 1'b1;
    tick();
    b0.seed_valid = 1'b0; b0.en = 1'b0;
    check("seed_en_z",     64'(b0.z),       64'hABCDE);
    check("seed_en_valid", 64'(b0.z_valid), 64'd1);

    // WARMUP=4, seed=1, en asserted during warm-up.
    b4.seed_valid = 1'b1; b4.seed = 64'h1;
    tick();
    b4.seed_valid = 1'b0;
    check("w4_load_valid",  64'(b4.z_valid),    64'd0);
    check("w4_load_reseed", 64'(b4.reseed_req), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      b4.en = (i < 4);
      tick();
      check("w4_warm_valid", 64'(b4.z_valid), (i == 4) ? 64'd1 : 64'd0);
    end
    b4.en = 1'b0;
    exp_state = ref_steps(64'h1, 80);
    check("w4_z_model", 64'(b4.z), 64'(exp_state[OUT_W-1:0]));
    check("w4_z_hand",  64'(b4.z), 64'hB0000);
    tick();
    check("w4_hold_z", 64'(b4.z), 64'hB0000);

    // RESEED_LIMIT=3: exhausts after the third word.
    b3.seed_valid = 1'b1; b3.seed = 64'h1;
    tick();
    b3.seed_valid = 1'b0;
    b3.en = 1'b1;
    tick();
    check("l3_use1_z",     64'(b3.z),       64'h00000);
    check("l3_use1_valid", 64'(b3.z_valid), 64'd1);
    tick();
    check("l3_use2_valid", 64'(b3.z_valid), 64'd1);
    tick();
    check("l3_use3_z",      64'(b3.z),          64'h00001);
    check("l3_use3_valid",  64'(b3.z_valid),    64'd0);
    check("l3_use3_reseed", 64'(b3.reseed_req), 64'd1);
    tick(); tick();
    check("l3_exh_z", 64'(b3.z), 64'h00001);
    b3.en = 1'b0;
    b3.seed_valid = 1'b1; b3.seed = 64'h1;
    tick();
    b3.seed_valid = 1'b0;
    check("l3_reseed_valid",  64'(b3.z_valid),    64'd1);
    check("l3_reseed_req",    64'(b3.reseed_req), 64'd0);
    b3.en = 1'b1; tick(); tick(); b3.en = 1'b0;
    check("l3_restart_valid", 64'(b3.z_valid), 64'd1);
    check("l3_restart_z",     64'(b3.z),       64'h00000);

    // rst mid-warm-up, concurrent with a seed offer.
    b4.seed_valid = 1'b1; b4.seed = 64'h5;
    tick();
    b4.seed_valid = 1'b0;
    tick();
    rst = 1'b1; b4.seed_valid = 1'b1; b4.seed = 64'h77;
    tick();
    rst = 1'b0; b4.seed_valid = 1'b0;
    check("rst_warm_z",      64'(b4.z),          64'd0);
    check("rst_warm_valid",  64'(b4.z_valid),    64'd0);
    check("rst_warm_reseed", 64'(b4.reseed_req), 64'd1);
    check("rst_warm_err",    64'(b4.seed_err),   64'd0);
    tick();
    check("rst_warm_valid2", 64'(b4.z_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
